// File: rtl/serial_adder_n.sv
// serial_adder_n: digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock.
// Ports: clk, rst_n (async, active-low), start/sub/a/b request (captured while not
// busy), busy, done (1-cycle pulse), soma (result, held), carryOut
// (no-borrow when sub=1), overflow (signed overflow, only with SERIAL_ADDER_OVF_EN).
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] soma,
    output logic             carryOut
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [WIDTH-1:0] sr;
    logic             c;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0]       sum;
    logic [DIGIT:0]         carry;
    logic [WIDTH+DIGIT-1:0] srCat;
    logic [WIDTH-1:0]       srNext;
    logic                   accept;
    logic                   last;

    // Ripple chain of full-adder cells over the low digit.
    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = c;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]     = aReg[i] ^ bReg[i] ^ carry[i];
            carry[i+1] = (aReg[i] & bReg[i])
                       | (carry[i] & (aReg[i] ^ bReg[i]));
        end
    end

    // Digit sums enter at the MSB end; after STEPS shifts the
    // first digit has reached bit 0.
    assign srCat  = {sum, sr};
    assign srNext = srCat[WIDTH+DIGIT-1:DIGIT];

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == RUN) && (cnt == CW'(STEPS - 1));

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (start) stateNext = RUN;
            RUN:  if (last)  stateNext = DONE;
            DONE: stateNext = start ? RUN : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aReg     <= '0;
            bReg     <= '0;
            sr       <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            soma     <= '0;
            carryOut <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            overflow <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                // Subtract as a + ~b + 1: the +1 rides in as the first carry.
                aReg <= a;
                bReg <= sub ? ~b : b;
                c    <= sub;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (state == RUN) begin
                aReg <= aReg >> DIGIT;
                bReg <= bReg >> DIGIT;
                c    <= carry[DIGIT];
                cnt  <= cnt + 1'b1;
                sr   <= srNext;
                if (last) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    soma     <= srNext;
                    carryOut <= carry[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                    overflow <= carry[DIGIT] ^ carry[DIGIT-1];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n: directed and random checks of serial_adder_n at DIGIT=1 and
// DIGIT=4 (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0;
    logic       start4 = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;

    logic       busy1, done1, co1;
    logic       busy4, done4, co4;
    logic [7:0] soma1, soma4;
    logic       ovf1, ovf4;

    int compared = 0;
    int mismatched = 0;
    bit useFour = 1'b0;
    logic [7:0] last1 = 8'h00;
    logic [7:0] last4 = 8'h00;

    always #5 clk = ~clk;

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub),
        .a(a), .b(b), .busy(busy1), .done(done1),
        .soma(soma1), .carryOut(co1)
`ifdef SERIAL_ADDER_OVF_EN
        , .overflow(ovf1)
`endif
    );

    serial_adder_n #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub),
        .a(a), .b(b), .busy(busy4), .done(done4),
        .soma(soma4), .carryOut(co4)
`ifdef SERIAL_ADDER_OVF_EN
        , .overflow(ovf4)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf1 = 1'b0;
    assign ovf4 = 1'b0;
`endif

    logic       selBusy, selDone, selCo, selOvf;
    logic [7:0] selSoma;
    assign selBusy = useFour ? busy4 : busy1;
    assign selDone = useFour ? done4 : done1;
    assign selCo   = useFour ? co4 : co1;
    assign selOvf  = useFour ? ovf4 : ovf1;
    assign selSoma = useFour ? soma4 : soma1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {overflow, carryOut, result} from plain two's-complement arithmetic.
    function automatic logic [9:0] model(input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic s);
        logic [7:0] yy;
        logic [8:0] t;
        logic       ov;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + {8'h00, s};
        ov = (x[7] == yy[7]) && (t[7] != x[7]);
        return {ov, t[8], t[7:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setStart(input bit four, input logic v);
        if (four) start4 = v;
        else      start1 = v;
    endtask

    task automatic doOp(input bit four, input logic [7:0] x,
                        input logic [7:0] y, input logic s,
                        input bit poke, input string tag);
        logic [9:0] exp;
        logic [7:0] held;
        int n;
        int steps;
        exp = model(x, y, s);
        steps = four ? 2 : 8;
        useFour = four;
        held = four ? last4 : last1;
        a = x; b = y; sub = s;
        setStart(four, 1'b1);
        tick;
        setStart(four, 1'b0);
        check({tag, ".busy0"}, {31'd0, selBusy}, 32'd1);
        check({tag, ".done0"}, {31'd0, selDone}, 32'd0);
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        n = 0;
        while (!selDone && n < 20) begin
            check({tag, ".hold"}, {24'd0, selSoma}, {24'd0, held});
            setStart(four, poke && n == 1);
            tick;
            n++;
        end
        setStart(four, 1'b0);
        check({tag, ".edges"}, n + 1, steps + 1);
        check({tag, ".soma"}, {24'd0, selSoma}, {24'd0, exp[7:0]});
        check({tag, ".cout"}, {31'd0, selCo}, {31'd0, exp[8]});
        check({tag, ".busy1"}, {31'd0, selBusy}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, ".ovf"}, {31'd0, selOvf}, {31'd0, exp[9]});
`endif
        tick;
        check({tag, ".pulse"}, {31'd0, selDone}, 32'd0);
        if (four) last4 = exp[7:0];
        else      last1 = exp[7:0];
    endtask

    initial begin : main
        logic [9:0] e1;
        logic [9:0] e2;
        int n;
        int m;

        #1;
        check("rst.busy", {31'd0, busy1}, 32'd0);
        check("rst.done", {31'd0, done1}, 32'd0);
        check("rst.soma", {24'd0, soma1}, 32'd0);
        check("rst.cout", {31'd0, co1}, 32'd0);
        check("rst.ovf", {31'd0, ovf1}, 32'd0);
        check("rst.busy4", {31'd0, busy4}, 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        doOp(1'b0, 8'h0F, 8'h01, 1'b0, 1'b0, "t1");
        doOp(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, "t2");
        doOp(1'b0, 8'h05, 8'h07, 1'b1, 1'b0, "t3a");
        doOp(1'b0, 8'h07, 8'h05, 1'b1, 1'b0, "t3b");
        doOp(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, "t4");
        doOp(1'b1, 8'h80, 8'h01, 1'b1, 1'b1, "t4s");

        // Abort mid-operation with an ignored start pulse in flight.
        useFour = 1'b0;
        a = 8'h10; b = 8'h20; sub = 1'b0;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        tick;
        a = 8'hAA; start1 = 1'b1;
        tick;
        start1 = 1'b0;
        tick;
        tick;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5.busy", {31'd0, busy1}, 32'd0);
        check("t5.soma", {24'd0, soma1}, 32'd0);
        check("t5.done", {31'd0, done1}, 32'd0);
        check("t5.cout", {31'd0, co1}, 32'd0);
        last1 = 8'h00;
        last4 = 8'h00;
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("t5.nodone", {31'd0, done1}, 32'd0);
            check("t5.idle", {31'd0, busy1}, 32'd0);
        end
        doOp(1'b0, 8'h10, 8'h20, 1'b0, 1'b0, "t5r");

        // Back-to-back with start held through DONE.
        useFour = 1'b0;
        e1 = model(8'h3C, 8'h55, 1'b0);
        e2 = model(8'h21, 8'h42, 1'b1);
        a = 8'h3C; b = 8'h55; sub = 1'b0;
        start1 = 1'b1;
        tick;
        a = 8'h21; b = 8'h42; sub = 1'b1;
        n = 0;
        while (!done1 && n < 20) begin
            tick;
            n++;
        end
        check("t6.lat", n + 1, 9);
        check("t6.soma1", {24'd0, soma1}, {24'd0, e1[7:0]});
        tick;
        start1 = 1'b0;
        check("t6.done", {31'd0, done1}, 32'd0);
        check("t6.busy", {31'd0, busy1}, 32'd1);
        m = 0;
        while (!done1 && m < 20) begin
            tick;
            m++;
        end
        check("t6.gap", m + 1, 9);
        check("t6.soma2", {24'd0, soma1}, {24'd0, e2[7:0]});
        check("t6.cout2", {31'd0, co1}, {31'd0, e2[8]});
        last1 = e2[7:0];
        tick;

        for (int i = 0; i < 16; i++) begin
            doOp(1'b0, 8'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom), "rnd1");
            doOp(1'b1, 8'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom), "rnd4");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
